lc4_divider_seq: RTL

LC4_DIVIDER_SEQ -- requirements
Module: lc4_divider_seq

---
 rtl/lc4_div_pkg.sv | 21 ++
 rtl/lc4_div_step.sv | 38 +++
 rtl/lc4_divider_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lc4_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc4_div_pkg
//  Purpose  : Shared constants and FSM state encoding for the LC4 sequential
//             divider (lc4_divider_seq and its step datapath).
//  Contents : LC4_DIV_WIDTH - default operand/result width
//             div_state_e   - divider FSM states (IDLE / BUSY / DONE)
//  Revision : 1.0 - initial release
// ============================================================================
package lc4_div_pkg;

   localparam int LC4_DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage : lc4_div_pkg
`default_nettype wire

// File: rtl/lc4_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : lc4_div_step
//  Purpose  : One combinational restoring shift-subtract division step.
//  Ports    : rem_in       [WIDTH-1:0] in  partial remainder before the step
//             dividend_bit             in  next dividend bit (MSB first)
//             divisor      [WIDTH-1:0] in  divisor
//             rem_out      [WIDTH-1:0] out partial remainder after the step
//             q_bit                    out quotient bit produced by the step
//  Revision : 1.0 - initial release
// ============================================================================
module lc4_div_step
   import lc4_div_pkg::*;
#(
   parameter int WIDTH = LC4_DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem_in, dividend_bit};
      diff    = shifted - {1'b0, divisor};
      // rem_in < divisor holds between steps, so a set top bit of the shifted
      // value already guarantees shifted >= divisor; otherwise diff[WIDTH] is
      // the borrow of the WIDTH+1-bit subtraction.
      q_bit   = shifted[WIDTH] | ~diff[WIDTH];
      rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule : lc4_div_step
`default_nettype wire

// File: rtl/lc4_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lc4_divider_seq
//  Purpose  : Sequential unsigned divider for the LC4 ALU (DIV / MOD results).
//             One restoring step per gwe-qualified clock, WIDTH steps per op.
//  Ports    : clk        in   clock, rising edge
//             rst_n      in   async active-low reset (released synchronously)
//             gwe        in   global write enable, 0 freezes all state
//             start      in   request a divide with current operands
//             cancel     in   abort (wins over start)
//             dividend   in   [WIDTH-1:0] unsigned dividend (rs)
//             divisor    in   [WIDTH-1:0] unsigned divisor (rt)
//             ready      out  a start can be accepted
//             done       out  results valid (high for the DONE cycle)
//             quotient   out  [WIDTH-1:0] registered quotient
//             remainder  out  [WIDTH-1:0] registered remainder
//  Config   : LC4_DIV_ZERO_FAST_EN - divisor 0 completes on the accepting edge
//  Revision : 1.0 - initial release
// ============================================================================
module lc4_divider_seq
   import lc4_div_pkg::*;
#(
   parameter int WIDTH = LC4_DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             gwe,
   input  logic             start,
   input  logic             cancel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // Reset synchronizer: assertion is immediate, release follows clk.
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_int_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_int_n  = rst_sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= rst_sync_d;
   end

   div_state_e       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0] dvd_q,       dvd_d;      // dividend in, quotient bits shift in at LSB
   logic [WIDTH-1:0] dvs_q,       dvs_d;
   logic [WIDTH-1:0] rem_q,       rem_d;      // partial remainder
   logic [WIDTH-1:0] quotient_q,  quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;
   logic [WIDTH-1:0] step_quo;

   lc4_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in       (rem_q),
      .dividend_bit (dvd_q[WIDTH-1]),
      .divisor      (dvs_q),
      .rem_out      (step_rem),
      .q_bit        (step_qbit)
   );

   assign step_quo = (dvd_q << 1) | WIDTH'(step_qbit);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      if (gwe) begin
         if (cancel) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_BUSY: begin
                  rem_d = step_rem;
                  dvd_d = step_quo;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     state_d = ST_DONE;
                     if (dvs_q == '0) begin
                        quotient_d  = '0;
                        remainder_d = '0;
                     end else begin
                        quotient_d  = step_quo;
                        remainder_d = step_rem;
                     end
                  end
               end
               default: begin
                  // IDLE and DONE both accept a new operation.
                  state_d = ST_IDLE;
                  if (start) begin
                     dvd_d   = dividend;
                     dvs_d   = divisor;
                     cnt_d   = '0;
                     rem_d   = '0;
                     state_d = ST_BUSY;
`ifdef LC4_DIV_ZERO_FAST_EN
                     if (divisor == '0) begin
                        state_d     = ST_DONE;
                        quotient_d  = '0;
                        remainder_d = '0;
                     end
`endif
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign ready     = (state_q != ST_BUSY);
   assign done      = (state_q == ST_DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule : lc4_divider_seq
`default_nettype wire
